// File: rtl/if_fetch_queue_pkg.sv
// Shared CPU definitions used by the fetch path.
// Holds the fetch queue entry type and PREIF exception bit positions.
package CPU_Defines;

  localparam int IF_EXC_W      = 19;
  localparam int IF_TLBRefill  = 8;
  localparam int IF_TLBInvalid = 9;

  typedef struct packed {
    logic [31:0]         pc;
    logic [31:0]         instr;
    logic [IF_EXC_W-1:0] exc;
    logic                filled;
  } FetchEntry;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch queue bus: PREIF issue, I$ response, ID handshake.
// master drives fetches/responses, slave is the queue.
interface if_fetch_queue_if #(
  parameter int EXC_W = CPU_Defines::IF_EXC_W
);

  logic             PREIF_Fire;
  logic [31:0]      PREIF_PC;
  logic [EXC_W-1:0] PREIF_ExceptType;
  logic             ICache_DataOK;
  logic [31:0]      ICache_RData;
  logic             Flush;
  logic             ID_Ready;
  logic             IF_Valid;
  logic [31:0]      IF_PC;
  logic [31:0]      IF_Instr;
  logic [EXC_W-1:0] IF_ExceptType;
  logic             Fetch_Allow;

  modport master (
    output PREIF_Fire, PREIF_PC, PREIF_ExceptType,
    output ICache_DataOK, ICache_RData,
    output Flush, ID_Ready,
    input  IF_Valid, IF_PC, IF_Instr, IF_ExceptType,
    input  Fetch_Allow
  );

  modport slave (
    input  PREIF_Fire, PREIF_PC, PREIF_ExceptType,
    input  ICache_DataOK, ICache_RData,
    input  Flush, ID_Ready,
    output IF_Valid, IF_PC, IF_Instr, IF_ExceptType,
    output Fetch_Allow
  );

endinterface

// File: rtl/if_fetch_queue.sv
// In-order fetch queue between PREIF and IF/ID.
// Entries reserved at issue, filled by I$; flushed responses discarded.
module if_fetch_queue
  import CPU_Defines::*;
#(
  parameter int DEPTH = 4,
  parameter int EXC_W = IF_EXC_W
) (
  input logic             clk,
  input logic             rst,
  if_fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] FULL = (CW+1)'(DEPTH);

  FetchEntry q [DEPTH];
  FetchEntry head_e;

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] fillp;
  logic [AW-1:0] fillp_nxt;
  logic [AW-1:0] idx;
  logic [AW-1:0] rel;
  logic [CW-1:0] count;
  logic [CW-1:0] discard;
  logic [CW-1:0] unfilled;
  logic [CW-1:0] pend;
  logic [CW-1:0] fdist;
  logic [CW-1:0] disc_fl;

  logic alloc;
  logic alloc_exc;
  logic pop;
  logic fill_ok;
  logic fill;
  logic drop;
  logic stop;
  logic done;

  assign head_e = q[head];

  assign bus.IF_Valid      = head_e.filled;
  assign bus.IF_PC         = head_e.pc;
  assign bus.IF_Instr      = head_e.instr;
  assign bus.IF_ExceptType = head_e.exc;

  assign bus.Fetch_Allow =
    ({1'b0, count} + {1'b0, discard}) < FULL;

  assign alloc     = bus.PREIF_Fire & ~bus.Flush;
  assign alloc_exc = |bus.PREIF_ExceptType;
  assign pop       = head_e.filled & bus.ID_Ready & ~bus.Flush;

  assign fdist   = {1'b0, fillp - head};
  assign fill_ok = (fdist < count) & ~q[fillp].filled;
  assign drop    = bus.ICache_DataOK & (discard != '0);
  assign fill    = bus.ICache_DataOK & ~drop & fill_ok;

  assign disc_fl = discard + unfilled
                 + CW'(bus.PREIF_Fire & ~alloc_exc)
                 - CW'(bus.ICache_DataOK);

  // Next fill pointer: skip entries that are filled after this cycle.
  always_comb begin
    fillp_nxt = fillp;
    pend      = count + CW'(alloc) - fdist;
    stop      = 1'b0;
    idx       = '0;
    done      = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx  = fillp + k[AW-1:0];
      done = q[idx].filled
           | (fill & (idx == fillp))
           | (alloc & alloc_exc & (idx == tail));
      if (!stop && (k[CW-1:0] < pend) && done)
        fillp_nxt = idx + 1'b1;
      else
        stop = 1'b1;
    end
  end

  // Count of live entries still awaiting an I$ response.
  always_comb begin
    unfilled = '0;
    rel      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = i[AW-1:0] - head;
      if (({1'b0, rel} < count) && !q[i].filled)
        unfilled = unfilled + 1'b1;
    end
  end

  // Entry array, pointers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head    <= '0;
      tail    <= '0;
      fillp   <= '0;
      count   <= '0;
      discard <= '0;
    end else if (bus.Flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head    <= '0;
      tail    <= '0;
      fillp   <= '0;
      count   <= '0;
      discard <= disc_fl;
    end else begin
      if (pop) q[head] <= '0;
      if (fill) begin
        q[fillp].instr  <= bus.ICache_RData;
        q[fillp].filled <= 1'b1;
      end
      if (alloc)
        q[tail] <= '{pc: bus.PREIF_PC, instr: '0,
                     exc: bus.PREIF_ExceptType,
                     filled: alloc_exc};
      head  <= head + AW'(pop);
      tail  <= tail + AW'(alloc);
      fillp <= fillp_nxt;
      count <= count + CW'(alloc) - CW'(pop);
      if (drop) discard <= discard - 1'b1;
    end
  end

  a_no_spurious_rsp: assert property (
    @(posedge clk) disable iff (rst)
    !(bus.ICache_DataOK && discard == '0 && !fill_ok)
  );

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: vector table, corner sequences,
// and random traffic against a queue-level reference model.
module tb_if_fetch_queue;
  import CPU_Defines::*;

  localparam int DEPTH = 4;
  localparam int EW    = IF_EXC_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.EXC_W(EW)) bus();

  if_fetch_queue #(.DEPTH(DEPTH), .EXC_W(EW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errs   = 0;
  int checks = 0;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   instr;
    logic [EW-1:0] exc;
    logic          filled;
  } ment_t;

  ment_t       mq[$];
  int          disc = 0;
  logic [31:0] icq[$];

  typedef struct {
    logic        f;
    logic [31:0] pc;
    logic        dok;
    logic [31:0] rd;
    logic        rdy;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic        eal;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic m_allow();
    return (mq.size() + disc) < DEPTH;
  endfunction

  task automatic model_step(input logic r, input logic f,
                            input logic [31:0] pc,
                            input logic [EW-1:0] ex,
                            input logic dok, input logic [31:0] rd,
                            input logic fl, input logic rdy);
    int  u;
    bit  hit;
    if (r) begin
      mq.delete();
      disc = 0;
    end else if (fl) begin
      u = 0;
      foreach (mq[i]) if (!mq[i].filled) u++;
      disc = disc + u + ((f && ex == '0) ? 1 : 0) - (dok ? 1 : 0);
      mq.delete();
    end else begin
      if (mq.size() > 0 && mq[0].filled && rdy) mq.delete(0);
      if (dok) begin
        if (disc > 0) disc--;
        else begin
          hit = 0;
          foreach (mq[i])
            if (!hit && !mq[i].filled) begin
              mq[i].instr  = rd;
              mq[i].filled = 1'b1;
              hit = 1;
            end
        end
      end
      if (f) mq.push_back('{pc, 32'h0, ex, ex != '0});
    end
  endtask

  task automatic compare_model();
    logic v;
    v = mq.size() > 0 && mq[0].filled;
    chk("m_valid", bus.IF_Valid, v);
    chk("m_allow", bus.Fetch_Allow, m_allow());
    if (v) begin
      chk("m_pc", bus.IF_PC, mq[0].pc);
      chk("m_instr", bus.IF_Instr, mq[0].instr);
      chk("m_exc", bus.IF_ExceptType, mq[0].exc);
    end else if (mq.size() == 0) begin
      chk("m_pc0", bus.IF_PC, 32'h0);
      chk("m_instr0", bus.IF_Instr, 32'h0);
      chk("m_exc0", bus.IF_ExceptType, 32'h0);
    end
  endtask

  task automatic cyc(input logic r, input logic f,
                     input logic [31:0] pc,
                     input logic [EW-1:0] ex,
                     input logic dok, input logic [31:0] rd,
                     input logic fl, input logic rdy);
    @(negedge clk);
    rst                  = r;
    bus.PREIF_Fire       = f;
    bus.PREIF_PC         = pc;
    bus.PREIF_ExceptType = ex;
    bus.ICache_DataOK    = dok;
    bus.ICache_RData     = rd;
    bus.Flush            = fl;
    bus.ID_Ready         = rdy;
    @(posedge clk);
    model_step(r, f, pc, ex, dok, rd, fl, rdy);
    #1;
    compare_model();
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  function automatic vec_t mk(input logic f, input logic [31:0] pc,
                              input logic dok, input logic [31:0] rd,
                              input logic rdy, input logic ev,
                              input logic [31:0] epc,
                              input logic [31:0] ein,
                              input logic eal);
    return '{f, pc, dok, rd, rdy, ev, epc, ein, eal};
  endfunction

  localparam logic [31:0] A0 = 32'hBFC0_0000;
  localparam logic [31:0] A1 = 32'hBFC0_0004;
  localparam logic [31:0] A2 = 32'hBFC0_0008;
  localparam logic [31:0] A3 = 32'hBFC0_000C;
  localparam logic [31:0] D0 = 32'h1000_0000;
  localparam logic [31:0] D1 = 32'h1000_0001;
  localparam logic [31:0] D2 = 32'h1000_0002;
  localparam logic [31:0] D3 = 32'h1000_0003;
  localparam logic [31:0] E0 = 32'h2000_0000;
  localparam logic [31:0] E1 = 32'h2000_0001;
  localparam logic [31:0] E2 = 32'h2000_0002;
  localparam logic [31:0] E3 = 32'h2000_0003;
  localparam logic [EW-1:0] XB8 = EW'(1) << 8;

  initial begin
    logic          r, f, dok, fl, rdy;
    logic [31:0]   pc, rd;
    logic [EW-1:0] ex;

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", bus.IF_Valid, 0);
    chk("rst_pc", bus.IF_PC, 0);
    chk("rst_instr", bus.IF_Instr, 0);
    chk("rst_exc", bus.IF_ExceptType, 0);
    chk("rst_allow", bus.Fetch_Allow, 1);

    tbl[0]  = mk(1, A0, 0, 0,  1, 0, 0,  0,  1);
    tbl[1]  = mk(1, A1, 1, D0, 1, 1, A0, D0, 1);
    tbl[2]  = mk(1, A2, 1, D1, 1, 1, A1, D1, 1);
    tbl[3]  = mk(1, A3, 1, D2, 1, 1, A2, D2, 1);
    tbl[4]  = mk(0, 0,  1, D3, 1, 1, A3, D3, 1);
    tbl[5]  = mk(0, 0,  0, 0,  1, 0, 0,  0,  1);
    tbl[6]  = mk(1, A0, 0, 0,  0, 0, 0,  0,  1);
    tbl[7]  = mk(1, A1, 1, E0, 0, 1, A0, E0, 1);
    tbl[8]  = mk(1, A2, 1, E1, 0, 1, A0, E0, 1);
    tbl[9]  = mk(1, A3, 1, E2, 0, 1, A0, E0, 0);
    tbl[10] = mk(0, 0,  1, E3, 0, 1, A0, E0, 0);
    tbl[11] = mk(0, 0,  0, 0,  1, 1, A1, E1, 1);
    tbl[12] = mk(0, 0,  0, 0,  1, 1, A2, E2, 1);
    tbl[13] = mk(0, 0,  0, 0,  1, 1, A3, E3, 1);
    tbl[14] = mk(0, 0,  0, 0,  1, 0, 0,  0,  1);

    for (int i = 0; i < 15; i++) begin
      cyc(0, tbl[i].f, tbl[i].pc, 0, tbl[i].dok, tbl[i].rd, 0,
          tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), bus.IF_Valid, tbl[i].ev);
      chk($sformatf("tbl%0d_allow", i), bus.Fetch_Allow, tbl[i].eal);
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pc", i), bus.IF_PC, tbl[i].epc);
        chk($sformatf("tbl%0d_instr", i), bus.IF_Instr, tbl[i].ein);
      end
    end

    // flush with three responses in flight
    cyc(0, 1, 32'hBFC0_0100, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'hBFC0_0104, 0, 0, 0, 0, 1);
    cyc(0, 1, 32'hBFC0_0108, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk("fl_valid", bus.IF_Valid, 0);
    chk("fl_allow", bus.Fetch_Allow, 1);
    cyc(0, 1, 32'h8000_0180, 0, 0, 0, 0, 0);
    chk("fl_allow_full", bus.Fetch_Allow, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 32'hDEAD_0000 + k, 0, 0);
      chk("fl_stale", bus.IF_Valid, 0);
    end
    cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0);
    chk("fl_new_valid", bus.IF_Valid, 1);
    chk("fl_new_pc", bus.IF_PC, 32'h8000_0180);
    chk("fl_new_instr", bus.IF_Instr, 32'h1234_5678);
    idle(1);
    chk("fl_drain", bus.IF_Valid, 0);

    // exception fetch behind two pending normal fetches
    cyc(0, 1, 32'hBFC0_0200, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hBFC0_0204, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0040_0000, XB8, 0, 0, 0, 0);
    chk("ex_wait", bus.IF_Valid, 0);
    cyc(0, 0, 0, 0, 1, 32'h3000_0000, 0, 0);
    chk("ex_p0", bus.IF_PC, 32'hBFC0_0200);
    cyc(0, 0, 0, 0, 1, 32'h3000_0001, 0, 0);
    idle(1);
    chk("ex_p1", bus.IF_Instr, 32'h3000_0001);
    idle(1);
    chk("ex_x_valid", bus.IF_Valid, 1);
    chk("ex_x_pc", bus.IF_PC, 32'h0040_0000);
    chk("ex_x_instr", bus.IF_Instr, 0);
    chk("ex_x_exc", bus.IF_ExceptType, XB8);
    idle(1);
    cyc(0, 1, 32'hBFC0_0300, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h3000_0300, 0, 0);
    chk("ex_y_pc", bus.IF_PC, 32'hBFC0_0300);
    chk("ex_y_instr", bus.IF_Instr, 32'h3000_0300);
    idle(1);

    // flush + fire + response in one cycle, two unfilled entries
    cyc(0, 1, 32'hBFC0_0400, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hBFC0_0404, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hBFC0_0408, 0, 1, 32'hDEAD_1000, 1, 1);
    chk("cc_empty", bus.IF_Valid, 0);
    cyc(0, 1, 32'h8000_0200, 0, 0, 0, 0, 0);
    chk("cc_allow", bus.Fetch_Allow, 1);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_1001, 0, 0);
    chk("cc_stale1", bus.IF_Valid, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_1002, 0, 0);
    chk("cc_stale2", bus.IF_Valid, 0);
    cyc(0, 0, 0, 0, 1, 32'h4000_0200, 0, 0);
    chk("cc_new_pc", bus.IF_PC, 32'h8000_0200);
    chk("cc_new_instr", bus.IF_Instr, 32'h4000_0200);
    idle(1);

    // reset mid-stream
    cyc(0, 1, 32'hBFC0_0500, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hBFC0_0504, 0, 1, 32'h5000_0000, 0, 0);
    cyc(0, 1, 32'hBFC0_0508, 0, 1, 32'h5000_0001, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("mr_valid", bus.IF_Valid, 0);
    chk("mr_pc", bus.IF_PC, 0);
    chk("mr_instr", bus.IF_Instr, 0);
    chk("mr_exc", bus.IF_ExceptType, 0);
    chk("mr_allow", bus.Fetch_Allow, 1);
    idle(0);

    // random traffic with an in-order I$ model
    icq.delete();
    for (int n = 0; n < 4000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      f   = !r && m_allow() && ($urandom_range(0, 2) != 0);
      ex  = ($urandom_range(0, 7) == 0) ?
            (EW'(1) << $urandom_range(0, EW - 1)) : '0;
      pc  = $urandom & 32'hFFFF_FFFC;
      dok = !r && icq.size() > 0 && ($urandom_range(0, 1) == 1);
      rd  = dok ? icq[0] : 32'h0;
      rdy = ($urandom_range(0, 3) != 0);
      cyc(r, f, pc, ex, dok, rd, fl, rdy);
      if (r) icq.delete();
      else begin
        if (dok) icq.delete(0);
        if (f && ex == '0) icq.push_back($urandom);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

In-order fetch queue between the PREIF stage (PC generation, ITLB, I$ request) and the IF/ID pipeline register. Every fetch is reserved an entry when PREIF issues it, and the entry is filled when the I$ response arrives. Stall (`ID_Ready` low) and redirect (`Flush`) are decoupled from in-flight cache requests: responses belonging to flushed fetches are counted and discarded.

## Interface
- `DEPTH`, default 4: queue entries; power of two, ≥2; also the max fetches in flight at the I$.
- `EXC_W`, default 19: exception-type vector width; matches the PREIF exception vector.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `PREIF_Fire`  in  1  a fetch is issued this cycle; only legal when `Fetch_Allow` is 1.
- `PREIF_PC`  in  32  PC of the issued fetch.
- `PREIF_ExceptType`  in  EXC_W  TLB exception of the fetch; nonzero means no I$ request was made.
- `ICache_DataOK`  in  1  one I$ response, in issue order.
- `ICache_RData`  in  32  response instruction word.
- `Flush`  in  1  redirect; kills every fetch issued up to and including this cycle.
- `ID_Ready`  in  1  downstream accepts the head entry.
- `IF_Valid`  out  1  head entry is filled.
- `IF_PC`  out  32  head PC.
- `IF_Instr`  out  32  head instruction.
- `IF_ExceptType`  out  EXC_W  head exception vector.
- `Fetch_Allow`  out  1  PREIF may issue a fetch this cycle.

## Operation
- Per-entry state: `pc`, `instr`, `exc`, `filled`. Pointers: `head`, `tail`, `fillp` (oldest unfilled). Counters: `count` (0..DEPTH) and `discard` (0..DEPTH).
- Allocate: on `PREIF_Fire & !Flush`, write `pc` and `exc` at `tail` and advance `tail`.
  - If `exc` is nonzero, the entry is written with `filled=1` and `instr=0`, and no response is expected.
  - Otherwise the entry is written with `filled=0`.
- Fill: on `ICache_DataOK`:
  - If `discard > 0`, decrement `discard`; the data is dropped.
  - Otherwise write `instr` at `fillp`, set `filled`, and advance `fillp` past that entry and any already-filled entries (exception entries).
- Pop: on `IF_Valid & ID_Ready & !Flush`, clear the entry at `head` and advance `head`.
- Flush: all entries are invalidated, all pointers are set to 0, and `count` is set to 0. `discard` becomes old `discard` + unfilled non-exception entries + (`PREIF_Fire` with zero exc ? 1 : 0) − (`ICache_DataOK` ? 1 : 0).
- `Fetch_Allow = (count + discard) < DEPTH`. This keeps total I$ in-flight ≤ DEPTH, so `discard` never overflows.
- An `ICache_DataOK` with no unfilled entry and `discard == 0` is a protocol error. It is asserted in simulation and ignored in RTL.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` and `discard` are log2(DEPTH)+1 bits.

## Timing
- Reset values: `IF_Valid=0`, `IF_PC=0`, `IF_Instr=0`, `IF_ExceptType=0`, `Fetch_Allow=1`. All entries are invalid, `discard=0`, and `count=0`.
- Outputs are driven combinationally from the head entry's registers only; there is no combinational path from inputs to the `IF_*` outputs.
- Latency and bypass:
  - A response in cycle N is visible at the outputs in N+1 if its entry is at `head`.
  - An exception fetch issued in cycle N is visible in N+1.
  - There is no same-cycle bypass.
- Full queue: `count==DEPTH` forces `Fetch_Allow=0`. A simultaneous pop does not raise `Fetch_Allow` in the same cycle.
- Simultaneous allocate, fill and pop in one cycle are all legal and independent.
  - Fill may target the entry being popped only if it is unfilled, which pop excludes.
  - `count` updates by +alloc − pop.
- Flush has priority over allocate and pop in the same cycle.
  - A fill in the flush cycle is consumed as an old-path response.
  - The first post-flush allocate happens in cycle flush+1 at entry 0.
- Reset mid-operation clears all state, including `discard`. The I$ is reset in the same cycle, so no stale responses follow.

## Structure
- Shared package (CPU_Defines): `IF_EXC_W` and a typedef `FetchEntry` {pc, instr, exc, filled}. The package also holds the `IF_TLBRefill` / `IF_TLBInvalid` vector positions already used by PREIF.
- Single module, with no sub-module. Entries are an array of `FetchEntry` with an inline pointer/counter datapath.

## Test plan
- Stream fetches: PC 0xBFC00000, then +4 issued each cycle; responses 1 cycle later; `ID_Ready=1` → `IF_PC` steps 0xBFC00000, 0xBFC00004 … with matching `IF_Instr`, and `IF_Valid` stays continuously high after the first fill.
- Back-pressure: `ID_Ready=0` while issuing 4 fetches → `Fetch_Allow` drops after the 4th, and the head holds 0xBFC00000. Releasing `ID_Ready` drains the entries in order.
- Flush with 3 responses in flight:
  - The 3 late `ICache_DataOK` are dropped (`discard` 3→0).
  - A new fetch at 0x80000180 is then delivered with its own data, not stale data.
- Exception fetch: `PREIF_ExceptType` bit 8 set at PC 0x00400000, issued behind 2 pending normal fetches.
  - It is output third, with `IF_Instr=0`.
  - No response is consumed for it.
- Corner cycle: flush, `PREIF_Fire` (normal) and `ICache_DataOK` in the same cycle with 2 unfilled entries → `discard=2`, and the queue is empty next cycle.
- Reset asserted mid-stream → next cycle all outputs are 0 and `Fetch_Allow=1`.
